// File: rtl/reg_write_buffer.sv
// Write-side buffer for the register file: in-order FIFO that drains one entry per
// cycle onto the Write_* port and offers newest-first bypass for two read addresses.

module reg_write_buffer_lookup #(
  parameter int ADDR_BITS    = 5,
  parameter int DATA_BITS    = 32,
  parameter int DEPTH        = 4,
  parameter bit ZERO_DISCARD = 1
) (
  input  logic [ADDR_BITS-1:0]            lookup,
  input  logic [DEPTH-1:0][ADDR_BITS-1:0] ord_reg,
  input  logic [DEPTH-1:0][DATA_BITS-1:0] ord_data,
  input  logic [DEPTH-1:0]                ord_vld,
  input  logic                            out_we,
  input  logic [ADDR_BITS-1:0]            out_reg,
  input  logic [DATA_BITS-1:0]            out_data,
  output logic                            hit,
  output logic [DATA_BITS-1:0]            hit_data
);
  // Entries are ordered oldest (0) to youngest, so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (out_we && out_reg == lookup) begin
      hit      = 1'b1;
      hit_data = out_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ord_vld[k] && ord_reg[k] == lookup) begin
        hit      = 1'b1;
        hit_data = ord_data[k];
      end
    end
    if (ZERO_DISCARD && lookup == '0) begin
      hit      = 1'b0;
      hit_data = '0;
    end
  end
endmodule

module reg_write_buffer #(
  parameter int ADDR_BITS    = 5,
  parameter int DATA_BITS    = 32,
  parameter int DEPTH        = 4,
  parameter bit ZERO_DISCARD = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   In_valid,
  output logic                   In_ready,
  input  logic [ADDR_BITS-1:0]   In_reg,
  input  logic [DATA_BITS-1:0]   In_data,
  input  logic                   Drain_en,
  output logic                   Write_enable,
  output logic [ADDR_BITS-1:0]   Write_reg,
  output logic [DATA_BITS-1:0]   Write_data,
  input  logic [ADDR_BITS-1:0]   Lookup_reg1,
  input  logic [ADDR_BITS-1:0]   Lookup_reg2,
  output logic                   Hit1,
  output logic                   Hit2,
  output logic [DATA_BITS-1:0]   Hit_data1,
  output logic [DATA_BITS-1:0]   Hit_data2,
  output logic [$clog2(DEPTH):0] Count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int NUM_LK = 2;

  typedef struct packed {
    logic [ADDR_BITS-1:0] rg;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               push, pop;

  assign In_ready = Count < (PTR_W+1)'(DEPTH);
  assign push     = In_valid && In_ready && !(ZERO_DISCARD && In_reg == '0);
  assign pop      = (Count != '0) && Drain_en;

  // Storage carries no reset; validity comes from the pointers and Count.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr] <= '{rg: In_reg, data: In_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      Count        <= '0;
      Write_enable <= 1'b0;
      Write_reg    <= '0;
      Write_data   <= '0;
    end else begin
      Write_enable <= pop;
      if (pop) begin
        Write_reg  <= mem[rd_ptr].rg;
        Write_data <= mem[rd_ptr].data;
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   Count <= Count + (PTR_W+1)'(1);
        2'b01:   Count <= Count - (PTR_W+1)'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Present the FIFO in age order for the bypass search.
  logic [DEPTH-1:0][ADDR_BITS-1:0] ord_reg;
  logic [DEPTH-1:0][DATA_BITS-1:0] ord_data;
  logic [DEPTH-1:0]                ord_vld;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    localparam logic [PTR_W-1:0] OFS = PTR_W'(k);
    logic [PTR_W-1:0] idx;
    assign idx         = rd_ptr + OFS;
    assign ord_reg[k]  = mem[idx].rg;
    assign ord_data[k] = mem[idx].data;
    assign ord_vld[k]  = (PTR_W+1)'(k) < Count;
  end

  logic [NUM_LK-1:0][ADDR_BITS-1:0] lk_reg;
  logic [NUM_LK-1:0]                lk_hit;
  logic [NUM_LK-1:0][DATA_BITS-1:0] lk_data;

  assign lk_reg    = {Lookup_reg2, Lookup_reg1};
  assign Hit1      = lk_hit[0];
  assign Hit2      = lk_hit[1];
  assign Hit_data1 = lk_data[0];
  assign Hit_data2 = lk_data[1];

  for (genvar l = 0; l < NUM_LK; l++) begin : g_lk
    reg_write_buffer_lookup #(
      .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
      .DEPTH(DEPTH), .ZERO_DISCARD(ZERO_DISCARD)
    ) u_lk (
      .lookup  (lk_reg[l]),
      .ord_reg (ord_reg),
      .ord_data(ord_data),
      .ord_vld (ord_vld),
      .out_we  (Write_enable),
      .out_reg (Write_reg),
      .out_data(Write_data),
      .hit     (lk_hit[l]),
      .hit_data(lk_data[l])
    );
  end
endmodule

// File: tb/tb_reg_write_buffer.sv
module tb_reg_write_buffer;
  logic        CLK = 1'b0;
  logic        RST, In_valid, In_ready, Drain_en, Write_enable, Hit1, Hit2;
  logic [4:0]  In_reg, Write_reg, Lookup_reg1, Lookup_reg2;
  logic [31:0] In_data, Write_data, Hit_data1, Hit_data2;
  logic [2:0]  Count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  reg_write_buffer dut (
    .CLK(CLK), .RST(RST), .In_valid(In_valid), .In_ready(In_ready),
    .In_reg(In_reg), .In_data(In_data), .Drain_en(Drain_en),
    .Write_enable(Write_enable), .Write_reg(Write_reg), .Write_data(Write_data),
    .Lookup_reg1(Lookup_reg1), .Lookup_reg2(Lookup_reg2),
    .Hit1(Hit1), .Hit2(Hit2), .Hit_data1(Hit_data1), .Hit_data2(Hit_data2),
    .Count(Count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $error("FAIL timeout: wait expired before end of test");
    $finish;
  end

  logic [4:0]  exp_reg [4];
  logic [31:0] exp_dat [4];

  initial begin
    RST = 1'b1; In_valid = 1'b0; In_reg = '0; In_data = '0; Drain_en = 1'b0;
    Lookup_reg1 = '0; Lookup_reg2 = '0;
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_count", Count, 3'd0);
    chk("rst_ready", In_ready, 1'b1);
    chk("rst_we", Write_enable, 1'b0);
    chk("rst_wreg", Write_reg, 5'd0);
    chk("rst_wdata", Write_data, 32'd0);
    chk("rst_hit1", Hit1, 1'b0);

    In_valid = 1'b1; In_reg = 5'd3; In_data = 32'hAAAA0001; Drain_en = 1'b1;
    Lookup_reg1 = 5'd3;
    tick();
    In_valid = 1'b0;
    chk("lat_count1", Count, 3'd1);
    chk("lat_we0", Write_enable, 1'b0);
    chk("lat_fifo_hit", Hit_data1, 32'hAAAA0001);
    tick();
    chk("lat_we1", Write_enable, 1'b1);
    chk("lat_wreg", Write_reg, 5'd3);
    chk("lat_wdata", Write_data, 32'hAAAA0001);
    chk("lat_count0", Count, 3'd0);
    chk("lat_out_hit", Hit1, 1'b1);
    tick();
    chk("lat_we_low", Write_enable, 1'b0);
    chk("lat_wreg_hold", Write_reg, 5'd3);
    chk("lat_nohit", Hit1, 1'b0);

    Drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_reg[i] = 5'(i + 1);
      exp_dat[i] = 32'(8'h11 * (i + 1));
      In_valid = 1'b1; In_reg = exp_reg[i]; In_data = exp_dat[i];
      tick();
    end
    chk("full_count", Count, 3'd4);
    chk("full_ready", In_ready, 1'b0);
    In_reg = 5'd9; In_data = 32'h99;
    tick();
    chk("stall_count", Count, 3'd4);
    chk("stall_we", Write_enable, 1'b0);
    In_valid = 1'b0; Drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we", Write_enable, 1'b1);
      chk("drain_reg", Write_reg, exp_reg[i]);
      chk("drain_data", Write_data, exp_dat[i]);
    end
    tick();
    chk("drain_done_we", Write_enable, 1'b0);
    chk("drain_done_count", Count, 3'd0);

    Drain_en = 1'b0; Lookup_reg1 = 5'd5;
    In_valid = 1'b1; In_reg = 5'd5; In_data = 32'h50;
    tick();
    In_data = 32'h55;
    tick();
    In_valid = 1'b0;
    #1;
    chk("byp_hit", Hit1, 1'b1);
    chk("byp_data", Hit_data1, 32'h55);
    Drain_en = 1'b1;
    tick();
    chk("byp_out_old", Write_data, 32'h50);
    chk("byp_data_after1", Hit_data1, 32'h55);
    tick();
    chk("byp_out_stage", Hit1, 1'b1);
    chk("byp_data_after2", Hit_data1, 32'h55);
    tick();
    chk("byp_clear_hit", Hit1, 1'b0);
    chk("byp_clear_data", Hit_data1, 32'h0);

    Lookup_reg2 = 5'd0;
    In_valid = 1'b1; In_reg = 5'd0; In_data = 32'hDEAD;
    #1;
    chk("z_ready", In_ready, 1'b1);
    tick();
    In_valid = 1'b0;
    chk("z_count", Count, 3'd0);
    chk("z_hit2", Hit2, 1'b0);
    tick();
    chk("z_we", Write_enable, 1'b0);
    chk("z_hit2b", Hit2, 1'b0);

    Drain_en = 1'b0;
    In_valid = 1'b1; In_reg = 5'd6; In_data = 32'h60;
    tick();
    In_reg = 5'd7; In_data = 32'h70;
    tick();
    chk("strm_pre_count", Count, 3'd2);
    Drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      In_reg = 5'(8 + i); In_data = 32'(8'h80 + 8'h10 * i);
      tick();
      chk("strm_count", Count, 3'd2);
      chk("strm_we", Write_enable, 1'b1);
      chk("strm_reg", Write_reg, 5'(6 + i));
      chk("strm_ready", In_ready, 1'b1);
    end
    In_valid = 1'b0;
    tick(); tick(); tick();
    chk("strm_empty", Count, 3'd0);

    Drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      In_valid = 1'b1; In_reg = 5'(12 + i); In_data = 32'(12 + i);
      tick();
    end
    In_valid = 1'b0; Drain_en = 1'b1;
    tick();
    chk("mid_we", Write_enable, 1'b1);
    chk("mid_reg", Write_reg, 5'd12);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    Lookup_reg1 = 5'd13; Lookup_reg2 = 5'd14;
    #1;
    chk("mrst_count", Count, 3'd0);
    chk("mrst_we", Write_enable, 1'b0);
    chk("mrst_ready", In_ready, 1'b1);
    chk("mrst_hit1", Hit1, 1'b0);
    chk("mrst_hit2", Hit2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_write", Write_enable, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_write_buffer.md
Name: reg_write_buffer

Overview:
- Producer-side companion of the register file's write-only port.
- Accepts register results over a valid/ready interface and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's Write_enable/Write_reg/Write_data port.
- Supplies bypass data for up to two read addresses, so readers see values still queued or in flight.

Parameters:
- ADDR_BITS, 5, register address width.
- DATA_BITS, 32, register data width.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- ZERO_DISCARD, 1, when 1, writes to register 0 are accepted but never stored, written or bypassed.

Ports:
- CLK  input  1  single clock, all state on rising edge.
- RST  input  1  synchronous reset, active-high.
- In_valid  input  1  producer offers a write.
- In_ready  output  1  buffer can accept; equals (count < DEPTH).
- In_reg  input  ADDR_BITS  destination register.
- In_data  input  DATA_BITS  write value.
- Drain_en  input  1  permits draining this cycle; low = hold, e.g. register file busy.
- Write_enable  output  1  registered; write strobe to the register file.
- Write_reg  output  ADDR_BITS  registered; write address.
- Write_data  output  DATA_BITS  registered; write data.
- Lookup_reg1  input  ADDR_BITS  bypass query address 1.
- Lookup_reg2  input  ADDR_BITS  bypass query address 2.
- Hit1  output  1  combinational; Lookup_reg1 matches a pending write.
- Hit2  output  1  combinational; Lookup_reg2 matches a pending write.
- Hit_data1  output  DATA_BITS  combinational; newest pending value for Lookup_reg1, 0 when no hit.
- Hit_data2  output  DATA_BITS  combinational; newest pending value for Lookup_reg2, 0 when no hit.
- Count  output  log2(DEPTH)+1  registered; number of FIFO entries.

Behaviour:
- Reset (RST=1 at an edge):
  - Read and write pointers and Count go to 0.
  - Write_enable, Write_reg and Write_data go to 0.
  - All entries are discarded, including mid-drain; In_ready=1 the next cycle.
- Accept: In_valid and In_ready at an edge is a handshake. With ZERO_DISCARD=1 and In_reg=0, the handshake completes but nothing is pushed.
- Drain, at each edge:
  - If Count>0 and Drain_en: Write_enable<=1, Write_reg/Write_data<=head entry, and the head is popped.
  - Otherwise Write_enable<=0; Write_reg/Write_data hold their previous values.
- Latency, empty buffer, Drain_en=1: pushed at edge N, popped at N+1, Write_enable high during N+1..N+2, register file writes at N+2.
- Push and pop at the same edge: Count unchanged.
- Full: In_ready=0, no push. In_ready does not depend on a same-cycle pop.
- Pointers wrap modulo DEPTH. Count saturates by construction (never exceeds DEPTH, never goes below 0).
- Bypass priority, newest first:
  1. Youngest matching FIFO entry.
  2. The output stage, when Write_enable=1 and Write_reg matches.
  3. No hit.
- Lookup_reg=0 with ZERO_DISCARD=1 never hits.
- Bypass does not include the current-cycle In_* offer.
- Ordering: writes reach the register file in acceptance order. Repeated addresses are all written, none coalesced.

Test Plan:
- Reset, then push (reg 3, 0xAAAA0001) with Drain_en=1: Write_enable=1, Write_reg=3, Write_data=0xAAAA0001 exactly one cycle, two edges after the push; Count returns to 0.
- Drain_en=0, push regs 1,2,3,4 with data 0x11,0x22,0x33,0x44: Count=4, In_ready=0, a fifth offer stalls. Raise Drain_en: four consecutive write cycles in order 1,2,3,4, then Write_enable=0.
- Drain_en=0, push (5,0x50) then (5,0x55); Lookup_reg1=5 gives Hit1=1, Hit_data1=0x55. Drain one entry: still 0x55. After both drain and the output stage clears: Hit1=0, Hit_data1=0.
- Push (0,0xDEAD) with ZERO_DISCARD=1: handshake completes, Count stays 0, no Write_enable, Lookup_reg2=0 gives Hit2=0.
- Count=2, Drain_en=1, continuous push each cycle: Count stays 2, one write per cycle, no stall.
- Fill 3 entries, assert RST for one edge mid-drain: Count=0, Write_enable=0 next cycle, the remaining entries are never written, Hit1=Hit2=0.
